// File: rtl/spi_host_master.sv
// rtl/spi_host_master.sv - Mode-0 SPI master, one byte per request, optional chip-select hold for bursts
module spi_host_master #(
    parameter int CLK_DIV  = 4,
    parameter int SS_SETUP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_dat,
    input  logic       tx_req,
    input  logic       ss_hold,
    output logic       tx_rdy,
    output logic [7:0] rx_dat,
    output logic       rx_valid,
    output logic       active,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_ss,
    input  logic       mcu_busy
);

    localparam int CNT_MAX = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCK_LO,
        ST_SCK_HI,
        ST_DONE,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_tx_q, shift_tx_d;
    logic [6:0]      shift_rx_q, shift_rx_d;
    logic            hold_q, hold_d;
    logic            sck_q, sck_d;
    logic            ss_q, ss_d;
    logic            active_q, active_d;
    logic [7:0]      rx_dat_q, rx_dat_d;
    logic            rx_valid_q, rx_valid_d;
    logic            busy_meta_q, busy_meta_d;
    logic            busy_s_q, busy_s_d;
    logic            accept;

    // Busy is only consulted in IDLE, so an accepted byte always runs to completion
    assign tx_rdy   = (state_q == ST_IDLE) && !busy_s_q;
    assign accept   = tx_rdy && tx_req;

    // MOSI is the top bit of the transmit shifter; it moves only at accept and on SCK falls
    assign spi_mosi = shift_tx_q[7];
    assign spi_clk  = sck_q;
    assign spi_ss   = ss_q;
    assign active   = active_q;
    assign rx_dat   = rx_dat_q;
    assign rx_valid = rx_valid_q;

    // State and datapath registers; async reset aborts any byte in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_tx_q  <= '0;
            shift_rx_q  <= '0;
            hold_q      <= 1'b0;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            active_q    <= 1'b0;
            rx_dat_q    <= '0;
            rx_valid_q  <= 1'b0;
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_tx_q  <= shift_tx_d;
            shift_rx_q  <= shift_rx_d;
            hold_q      <= hold_d;
            sck_q       <= sck_d;
            ss_q        <= ss_d;
            active_q    <= active_d;
            rx_dat_q    <= rx_dat_d;
            rx_valid_q  <= rx_valid_d;
            busy_meta_q <= busy_meta_d;
            busy_s_q    <= busy_s_d;
        end
    end

    // Next-state and datapath logic for the byte sequencer and the busy synchroniser
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_tx_d  = shift_tx_q;
        shift_rx_d  = shift_rx_q;
        hold_d      = hold_q;
        sck_d       = sck_q;
        ss_d        = ss_q;
        active_d    = active_q;
        rx_dat_d    = rx_dat_q;
        rx_valid_d  = 1'b0;
        busy_meta_d = mcu_busy;
        busy_s_d    = busy_meta_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_tx_d = tx_dat;
                    hold_d     = ss_hold;
                    active_d   = 1'b1;
                    ss_d       = 1'b0;
                    cnt_d      = '0;
                    bit_d      = '0;
                    // A held burst already has chip select low, so skip the setup delay
                    state_d    = ss_q ? ST_SETUP : ST_SCK_LO;
                end
            end

            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SCK_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SCK_LO: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    state_d = ST_SCK_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SCK_HI: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d      = '0;
                    sck_d      = 1'b0;
                    // MISO is taken at the very end of the high phase to tolerate slave output delay
                    shift_rx_d = {shift_rx_q[5:0], spi_miso};
                    if (bit_q == 3'd7) begin
                        rx_dat_d   = {shift_rx_q, spi_miso};
                        rx_valid_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        bit_d      = bit_q + 3'd1;
                        shift_tx_d = {shift_tx_q[6:0], 1'b0};
                        state_d    = ST_SCK_LO;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (hold_q) begin
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    ss_d       = 1'b1;
                    shift_tx_d = '0;
                    cnt_d      = '0;
                    state_d    = ST_GAP;
                end
            end

            ST_GAP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_host_master.sv
// tb/tb_spi_host_master.sv - directed self-checking bench for spi_host_master
module tb_spi_host_master;

    logic       clk;
    logic       rst_n;
    logic       mcu_busy;
    logic       b_busy;

    logic [7:0] a_tx_dat;
    logic       a_tx_req;
    logic       a_ss_hold;
    logic       a_tx_rdy;
    logic [7:0] a_rx_dat;
    logic       a_rx_valid;
    logic       a_active;
    logic       a_sck;
    logic       a_mosi;
    logic       a_miso;
    logic       a_ss;

    logic [7:0] b_tx_dat;
    logic       b_tx_req;
    logic       b_ss_hold;
    logic       b_tx_rdy;
    logic [7:0] b_rx_dat;
    logic       b_rx_valid;
    logic       b_active;
    logic       b_sck;
    logic       b_mosi;
    logic       b_miso;
    logic       b_ss;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    spi_host_master #(.CLK_DIV(4), .SS_SETUP(2)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_dat   (a_tx_dat),
        .tx_req   (a_tx_req),
        .ss_hold  (a_ss_hold),
        .tx_rdy   (a_tx_rdy),
        .rx_dat   (a_rx_dat),
        .rx_valid (a_rx_valid),
        .active   (a_active),
        .spi_clk  (a_sck),
        .spi_mosi (a_mosi),
        .spi_miso (a_miso),
        .spi_ss   (a_ss),
        .mcu_busy (mcu_busy)
    );

    spi_host_master #(.CLK_DIV(1), .SS_SETUP(1)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_dat   (b_tx_dat),
        .tx_req   (b_tx_req),
        .ss_hold  (b_ss_hold),
        .tx_rdy   (b_tx_rdy),
        .rx_dat   (b_rx_dat),
        .rx_valid (b_rx_valid),
        .active   (b_active),
        .spi_clk  (b_sck),
        .spi_mosi (b_mosi),
        .spi_miso (b_miso),
        .spi_ss   (b_ss),
        .mcu_busy (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count for SCK period measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Slave A: mode-0 slave answering from a per-byte response table
    logic [7:0] sa_tab [0:15];
    logic [7:0] sa_got [0:15];
    logic [7:0] sa_sh       = 8'h00;
    logic [7:0] sa_rx       = 8'h00;
    logic [3:0] sa_idx      = 4'd0;
    int         sa_bits     = 0;
    int         sa_rises    = 0;
    int         sa_ss_rises = 0;
    logic       sa_prev_sck = 1'b0;
    logic       sa_prev_ss  = 1'b1;
    assign a_miso = sa_sh[7];

    always @(negedge clk) begin
        if (!rst_n) begin
            sa_bits     <= 0;
            sa_prev_sck <= 1'b0;
            sa_prev_ss  <= 1'b1;
        end else begin
            sa_prev_sck <= a_sck;
            sa_prev_ss  <= a_ss;
            if (!sa_prev_ss && a_ss) sa_ss_rises <= sa_ss_rises + 1;
            if (sa_prev_ss && !a_ss) begin
                sa_sh <= sa_tab[sa_idx];
            end else if (!sa_prev_sck && a_sck) begin
                sa_rx    <= {sa_rx[6:0], a_mosi};
                sa_rises <= sa_rises + 1;
                if (sa_bits == 7) begin
                    sa_bits        <= 0;
                    sa_got[sa_idx] <= {sa_rx[6:0], a_mosi};
                    sa_idx         <= sa_idx + 4'd1;
                end else begin
                    sa_bits <= sa_bits + 1;
                end
            end else if (sa_prev_sck && !a_sck) begin
                if (sa_bits == 0) sa_sh <= sa_tab[sa_idx];
                else              sa_sh <= {sa_sh[6:0], 1'b0};
            end
        end
    end

    // Slave B: mode-0 slave that echoes the previously received byte
    logic [7:0] sb_sh       = 8'h00;
    logic [7:0] sb_rx       = 8'h00;
    logic [7:0] sb_last     = 8'h00;
    int         sb_bits     = 0;
    int         sb_t_last   = 0;
    int         sb_t_prev   = 0;
    logic       sb_prev_sck = 1'b0;
    logic       sb_prev_ss  = 1'b1;
    assign b_miso = sb_sh[7];

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_bits     <= 0;
            sb_prev_sck <= 1'b0;
            sb_prev_ss  <= 1'b1;
        end else begin
            sb_prev_sck <= b_sck;
            sb_prev_ss  <= b_ss;
            if (sb_prev_ss && !b_ss) begin
                sb_sh <= sb_last;
            end else if (!sb_prev_sck && b_sck) begin
                sb_rx     <= {sb_rx[6:0], b_mosi};
                sb_t_prev <= sb_t_last;
                sb_t_last <= cyc;
                if (sb_bits == 7) begin
                    sb_bits <= 0;
                    sb_last <= {sb_rx[6:0], b_mosi};
                end else begin
                    sb_bits <= sb_bits + 1;
                end
            end else if (sb_prev_sck && !b_sck) begin
                if (sb_bits == 0) sb_sh <= sb_last;
                else              sb_sh <= {sb_sh[6:0], 1'b0};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one byte on DUT A; lat counts cycles from the accept cycle to rx_valid (999 = timeout)
    task automatic xfer_a(input logic [7:0] d, input logic h, input int busy_at, output int lat);
        int guard;
        a_tx_dat  = d;
        a_ss_hold = h;
        a_tx_req  = 1'b1;
        guard     = 0;
        while (!a_tx_rdy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        lat = 0;
        if (!a_tx_rdy) begin
            a_tx_req = 1'b0;
            lat      = 999;
        end else begin
            do begin
                @(negedge clk);
                lat++;
                a_tx_req = 1'b0;
                if (lat == busy_at) mcu_busy = 1'b1;
            end while (!a_rx_valid && lat < 300);
            if (!a_rx_valid) lat = 999;
        end
    endtask

    task automatic xfer_b(input logic [7:0] d, output int lat);
        int guard;
        b_tx_dat  = d;
        b_ss_hold = 1'b0;
        b_tx_req  = 1'b1;
        guard     = 0;
        while (!b_tx_rdy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        lat = 0;
        if (!b_tx_rdy) begin
            b_tx_req = 1'b0;
            lat      = 999;
        end else begin
            do begin
                @(negedge clk);
                lat++;
                b_tx_req = 1'b0;
            end while (!b_rx_valid && lat < 300);
            if (!b_rx_valid) lat = 999;
        end
    endtask

    initial begin
        int lat;
        int r0;
        int s0;
        int guard;
        int v;

        rst_n     = 1'b0;
        mcu_busy  = 1'b0;
        b_busy    = 1'b0;
        a_tx_dat  = 8'h00;
        a_tx_req  = 1'b0;
        a_ss_hold = 1'b0;
        b_tx_dat  = 8'h00;
        b_tx_req  = 1'b0;
        b_ss_hold = 1'b0;
        sa_tab[0] = 8'h3C;
        sa_tab[1] = 8'h81;
        sa_tab[2] = 8'h42;
        sa_tab[3] = 8'h24;
        sa_tab[4] = 8'h96;
        sa_tab[5] = 8'hC3;
        for (int i = 6; i < 16; i++) sa_tab[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ss", 32'(a_ss), 32'd1);
        chk("rst_sck", 32'(a_sck), 32'd0);
        chk("rst_mosi", 32'(a_mosi), 32'd0);
        chk("rst_rx_valid", 32'(a_rx_valid), 32'd0);
        chk("rst_rx_dat", 32'(a_rx_dat), 32'h00);
        chk("rst_active", 32'(a_active), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx_rdy_a", 32'(a_tx_rdy), 32'd1);
        chk("rst_tx_rdy_b", 32'(b_tx_rdy), 32'd1);

        // Single byte 0xA5, slave answers 0x3C
        r0 = sa_rises;
        xfer_a(8'hA5, 1'b0, 0, lat);
        chk("t2_latency", 32'(lat), 32'd67);
        chk("t2_rx_dat", 32'(a_rx_dat), 32'h3C);
        chk("t2_active", 32'(a_active), 32'd1);
        chk("t2_mosi_bits", 32'(sa_got[0]), 32'hA5);
        chk("t2_sck_rises", 32'(sa_rises - r0), 32'd8);
        @(negedge clk);
        chk("t2_ss_released", 32'(a_ss), 32'd1);
        chk("t2_mosi_idle", 32'(a_mosi), 32'd0);
        chk("t2_gap_rdy0", 32'(a_tx_rdy), 32'd0);
        @(negedge clk);
        chk("t2_gap_rdy1", 32'(a_tx_rdy), 32'd0);
        @(negedge clk);
        chk("t2_tx_rdy", 32'(a_tx_rdy), 32'd1);
        chk("t2_active_low", 32'(a_active), 32'd0);

        // Held burst 0x01, 0x02, 0x03
        r0 = sa_rises;
        s0 = sa_ss_rises;
        xfer_a(8'h01, 1'b1, 0, lat);
        chk("t3_lat0", 32'(lat), 32'd67);
        chk("t3_rx0", 32'(a_rx_dat), 32'h81);
        xfer_a(8'h02, 1'b1, 0, lat);
        chk("t3_lat1", 32'(lat), 32'd65);
        chk("t3_rx1", 32'(a_rx_dat), 32'h42);
        xfer_a(8'h03, 1'b0, 0, lat);
        chk("t3_lat2", 32'(lat), 32'd65);
        chk("t3_rx2", 32'(a_rx_dat), 32'h24);
        chk("t3_ss_low_at_last", 32'(a_ss), 32'd0);
        chk("t3_no_ss_release", 32'(sa_ss_rises - s0), 32'd0);
        chk("t3_sck_rises", 32'(sa_rises - r0), 32'd24);
        chk("t3_mosi_bytes", {8'h00, sa_got[1], sa_got[2], sa_got[3]}, 32'h00010203);
        @(negedge clk);
        chk("t3_ss_release", 32'(a_ss), 32'd1);

        // Flow control: busy before request blocks the byte
        mcu_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_busy_rdy", 32'(a_tx_rdy), 32'd0);
        a_tx_dat  = 8'h5A;
        a_ss_hold = 1'b0;
        a_tx_req  = 1'b1;
        r0        = sa_rises;
        repeat (10) @(negedge clk);
        chk("t4_no_sck", 32'(sa_rises - r0), 32'd0);
        chk("t4_ss_idle", 32'(a_ss), 32'd1);
        mcu_busy = 1'b0;
        @(negedge clk);
        chk("t4_sync_lat1", 32'(a_tx_rdy), 32'd0);
        @(negedge clk);
        chk("t4_sync_lat2", 32'(a_tx_rdy), 32'd1);
        xfer_a(8'h5A, 1'b0, 0, lat);
        chk("t4_lat", 32'(lat), 32'd67);
        chk("t4_rx", 32'(a_rx_dat), 32'h96);
        // Busy rising mid-byte does not disturb the byte in flight
        xfer_a(8'h0F, 1'b0, 20, lat);
        chk("t4_mid_busy_lat", 32'(lat), 32'd67);
        chk("t4_mid_busy_rx", 32'(a_rx_dat), 32'hC3);
        chk("t4_mid_busy_mosi", 32'(sa_got[5]), 32'h0F);
        repeat (4) @(negedge clk);
        chk("t4_busy_after", 32'(a_tx_rdy), 32'd0);
        mcu_busy = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset after three SCK rises
        a_tx_dat  = 8'hF0;
        a_ss_hold = 1'b0;
        a_tx_req  = 1'b1;
        r0        = sa_rises;
        guard     = 0;
        while ((sa_rises - r0) < 3 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("t5_reached_3_rises", 32'(sa_rises - r0), 32'd3);
        chk("t5_sck_high_before", 32'(a_sck), 32'd1);
        a_tx_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_ss", 32'(a_ss), 32'd1);
        chk("t5_sck", 32'(a_sck), 32'd0);
        chk("t5_mosi", 32'(a_mosi), 32'd0);
        chk("t5_rx_valid", 32'(a_rx_valid), 32'd0);
        chk("t5_rx_dat", 32'(a_rx_dat), 32'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        v = 0;
        repeat (80) begin
            @(negedge clk);
            if (a_rx_valid) v++;
        end
        chk("t5_no_rx_valid", 32'(v), 32'd0);
        chk("t5_tx_rdy", 32'(a_tx_rdy), 32'd1);

        // Fastest settings on DUT B with an echoing slave
        xfer_b(8'hFF, lat);
        chk("t6_lat0", 32'(lat), 32'd18);
        chk("t6_rx0", 32'(b_rx_dat), 32'h00);
        xfer_b(8'h00, lat);
        chk("t6_lat1", 32'(lat), 32'd18);
        chk("t6_rx1", 32'(b_rx_dat), 32'hFF);
        chk("t6_sck_period", 32'(sb_t_last - sb_t_prev), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
